// File: rtl/xm23_alu_if.sv
// xm23_alu_if: operand/result bundle between the XM23 control path and the ALU.
//   alu_E      - latch a new operation on this clock edge
//   alu_op     - [5] byte mode, [4:0] operation code
//   s_bus      - source operand
//   d_bus      - destination operand
//   PSW_in     - current PSW (C=0, Z=1, N=2, SLP=3, V=4)
//   alu_out    - registered result
//   PSW_out    - registered PSW with updated flags
//   psw_update - one-cycle strobe: write PSW_out to the PSW
// master drives operands (control unit / testbench), slave is the ALU.
interface xm23_alu_if;
    logic        alu_E;
    logic [5:0]  alu_op;
    logic [15:0] s_bus;
    logic [15:0] d_bus;
    logic [15:0] PSW_in;
    logic [15:0] alu_out;
    logic [15:0] PSW_out;
    logic        psw_update;

    modport master (
        output alu_E, alu_op, s_bus, d_bus, PSW_in,
        input  alu_out, PSW_out, psw_update
    );

    modport slave (
        input  alu_E, alu_op, s_bus, d_bus, PSW_in,
        output alu_out, PSW_out, psw_update
    );
endinterface

// File: rtl/xm23_alu.sv
// xm23_alu: registered ALU for the XM23 datapath, one cycle latency.
//   Clock   - rising-edge system clock
//   Reset_n - asynchronous active-low reset, clears all outputs
//   bus     - xm23_alu_if slave: operands/op/PSW in, result/PSW/strobe out
// Byte mode works on bits [7:0] with flags and carry taken at bit 7; the
// upper byte of the result passes d_bus through. SWPB and SXT are always word.
module xm23_alu (
    input  logic        Clock,
    input  logic        Reset_n,
    xm23_alu_if.slave   bus
);

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_ADDC = 5'd1,  OP_SUB  = 5'd2,  OP_SUBC = 5'd3,
        OP_DADD = 5'd4,  OP_CMP  = 5'd5,  OP_XOR  = 5'd6,  OP_AND  = 5'd7,
        OP_OR   = 5'd8,  OP_BIT  = 5'd9,  OP_BIC  = 5'd10, OP_BIS  = 5'd11,
        OP_MOV  = 5'd12, OP_SWAP = 5'd13, OP_SRA  = 5'd14, OP_RRC  = 5'd15,
        OP_SWPB = 5'd16, OP_SXT  = 5'd17
    } alu_op_e;

    alu_op_e     code;
    logic        byte_m;
    logic        c_in;
    logic        is_sub;
    logic        cin;
    logic [15:0] d, s, b_op;
    logic [16:0] sum_w;
    logic [8:0]  sum_b;
    logic [15:0] arith_r;
    logic        arith_c, arith_v;
    logic [5:0]  nib;
    logic        dc;
    logic [15:0] dec_r;
    logic [15:0] res_full;   // result before the byte-mode upper-byte merge
    logic [15:0] fres;       // value the Z/N flags are derived from
    logic [15:0] out_next;
    logic        new_c, new_v;
    logic        upd_flags;
    logic [15:0] psw_next;

    always_comb begin
        code     = alu_op_e'(bus.alu_op[4:0]);
        byte_m   = bus.alu_op[5] && (code != OP_SWPB) && (code != OP_SXT);
        d        = bus.d_bus;
        s        = bus.s_bus;
        c_in     = bus.PSW_in[0];

        is_sub   = (code == OP_SUB) || (code == OP_SUBC) || (code == OP_CMP);
        b_op     = is_sub ? ~s : s;
        case (code)
            OP_ADDC, OP_SUBC:  cin = c_in;
            OP_SUB,  OP_CMP:   cin = 1'b1;
            default:           cin = 1'b0;
        endcase

        sum_w    = {1'b0, d} + {1'b0, b_op} + 17'(cin);
        sum_b    = {1'b0, d[7:0]} + {1'b0, b_op[7:0]} + 9'(cin);
        if (byte_m) begin
            arith_r = {8'h00, sum_b[7:0]};
            arith_c = sum_b[8];
            arith_v = (d[7] == b_op[7]) && (sum_b[7] != d[7]);
        end else begin
            arith_r = sum_w[15:0];
            arith_c = sum_w[16];
            arith_v = (d[15] == b_op[15]) && (sum_w[15] != d[15]);
        end

        // BCD add: each nibble carries into the next; only the low two
        // nibbles participate in byte mode.
        nib   = '0;
        dc    = c_in;
        dec_r = d;
        for (int unsigned i = 0; i < 4; i++) begin
            if (!byte_m || i < 2) begin
                nib = 6'(d[4*i +: 4]) + 6'(s[4*i +: 4]) + 6'(dc);
                if (nib > 6'd9) begin
                    nib = nib + 6'd6;
                    dc  = 1'b1;
                end else begin
                    dc  = 1'b0;
                end
                dec_r[4*i +: 4] = nib[3:0];
            end
        end

        res_full  = d;
        fres      = d;
        new_c     = bus.PSW_in[0];
        new_v     = bus.PSW_in[4];
        upd_flags = 1'b1;

        case (code)
            OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
                res_full = arith_r;
                fres     = arith_r;
                new_c    = arith_c;
                new_v    = arith_v;
            end
            OP_CMP: begin
                fres  = arith_r;
                new_c = arith_c;
                new_v = arith_v;
            end
            OP_DADD: begin
                res_full = dec_r;
                fres     = dec_r;
                new_c    = dc;
            end
            OP_XOR: begin res_full = d ^ s;  fres = res_full; end
            OP_AND: begin res_full = d & s;  fres = res_full; end
            OP_OR:  begin res_full = d | s;  fres = res_full; end
            OP_BIT: fres = d & s;
            OP_BIC: begin res_full = d & ~s; fres = res_full; end
            OP_BIS: begin res_full = d | s;  fres = res_full; end
            OP_MOV, OP_SWAP: begin
                res_full  = s;
                upd_flags = 1'b0;
            end
            OP_SRA: begin
                res_full = byte_m ? {8'h00, d[7], d[7:1]} : {d[15], d[15:1]};
                fres     = res_full;
                new_c    = d[0];
            end
            OP_RRC: begin
                res_full = byte_m ? {8'h00, c_in, d[7:1]} : {c_in, d[15:1]};
                fres     = res_full;
                new_c    = d[0];
            end
            OP_SWPB: begin res_full = {d[7:0], d[15:8]};   fres = res_full; end
            OP_SXT:  begin res_full = {{8{d[7]}}, d[7:0]}; fres = res_full; end
            default: upd_flags = 1'b0;
        endcase

        out_next = byte_m ? {d[15:8], res_full[7:0]} : res_full;

        psw_next = bus.PSW_in;
        if (upd_flags) begin
            psw_next[0] = new_c;
            psw_next[1] = byte_m ? (fres[7:0] == 8'h00) : (fres == 16'h0000);
            psw_next[2] = byte_m ? fres[7] : fres[15];
            psw_next[4] = new_v;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.alu_out    <= '0;
            bus.PSW_out    <= '0;
            bus.psw_update <= 1'b0;
        end else if (bus.alu_E) begin
            bus.alu_out    <= out_next;
            bus.PSW_out    <= psw_next;
            bus.psw_update <= upd_flags;
        end else begin
            bus.psw_update <= 1'b0;
        end
    end

endmodule

// File: tb/tb_xm23_alu.sv
// tb_xm23_alu: directed-vector bench for xm23_alu. The driver issues each
// operation on a falling edge and queues the hand-computed response; the
// monitor pops and compares on the falling edge after each latched operation.
module tb_xm23_alu;

    logic Clock = 1'b0;
    logic Reset_n = 1'b0;

    xm23_alu_if bus ();

    xm23_alu dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus.slave)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        string       name;
        logic [15:0] out;
        logic [15:0] psw;
        logic        upd;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   check_cnt = 0;
    logic e_q;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
        check_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // An operation is latched on a rising edge with alu_E=1 outside reset.
    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) e_q <= 1'b0;
        else          e_q <= bus.alu_E;
    end

    always @(negedge Clock) begin
        if (e_q) begin
            if (exp_q.size() == 0) begin
                check_cnt++;
                $display("FAIL unexpected_output: got alu_out %h with no queued expectation", bus.alu_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, ".alu_out"},    bus.alu_out,             e.out);
                chk({e.name, ".PSW_out"},    bus.PSW_out,             e.psw);
                chk({e.name, ".psw_update"}, 16'(bus.psw_update),     16'(e.upd));
            end
        end
    end

    task automatic issue(input string name, input logic [5:0] op, input logic [15:0] d,
                         input logic [15:0] s, input logic [15:0] psw,
                         input logic [15:0] eo, input logic [15:0] ep, input logic eu);
        exp_t e;
        @(negedge Clock);
        bus.alu_op = op;
        bus.d_bus  = d;
        bus.s_bus  = s;
        bus.PSW_in = psw;
        bus.alu_E  = 1'b1;
        e.name = name; e.out = eo; e.psw = ep; e.upd = eu;
        exp_q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bus.alu_E  = 1'b0;
        bus.alu_op = '0;
        bus.d_bus  = '0;
        bus.s_bus  = '0;
        bus.PSW_in = '0;
        #12;
        chk("reset.alu_out",    bus.alu_out,         16'h0000);
        chk("reset.PSW_out",    bus.PSW_out,         16'h0000);
        chk("reset.psw_update", 16'(bus.psw_update), 16'h0000);
        @(negedge Clock);
        Reset_n = 1'b1;

        //      name          op     D        S        PSW_in   alu_out  PSW_out  upd
        issue("add_w_ovf",  6'h00, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 16'h0014, 1'b1);
        issue("sub_b_zero", 6'h22, 16'h1234, 16'h0034, 16'h0000, 16'h1200, 16'h0003, 1'b1);
        issue("dadd_w_1",   6'h04, 16'h0999, 16'h0001, 16'h0000, 16'h1000, 16'h0000, 1'b1);
        issue("dadd_w_2",   6'h04, 16'h9999, 16'h0001, 16'h0000, 16'h0000, 16'h0003, 1'b1);
        issue("rrc_w",      6'h0F, 16'h0001, 16'h0000, 16'h0001, 16'h8000, 16'h0005, 1'b1);
        issue("sxt",        6'h11, 16'h1280, 16'h0000, 16'h0000, 16'hFF80, 16'h0004, 1'b1);
        issue("sxt_bytebit",6'h31, 16'h1280, 16'h0000, 16'h0000, 16'hFF80, 16'h0004, 1'b1);
        issue("addc_w",     6'h01, 16'hFFFF, 16'h0000, 16'h0001, 16'h0000, 16'h0003, 1'b1);
        issue("subc_w",     6'h03, 16'h0005, 16'h0005, 16'h0000, 16'hFFFF, 16'h0004, 1'b1);
        issue("cmp_w",      6'h05, 16'h8000, 16'h0001, 16'h0000, 16'h8000, 16'h0011, 1'b1);
        issue("xor_b",      6'h26, 16'hAB55, 16'h1255, 16'h0011, 16'hAB00, 16'h0013, 1'b1);
        issue("bit_w",      6'h09, 16'h00F0, 16'h8080, 16'h0006, 16'h00F0, 16'h0000, 1'b1);
        issue("bic_w",      6'h0A, 16'hFFFF, 16'h00FF, 16'h0000, 16'hFF00, 16'h0004, 1'b1);
        issue("bis_w",      6'h0B, 16'h8000, 16'h0001, 16'h0000, 16'h8001, 16'h0004, 1'b1);
        issue("or_w_zero",  6'h08, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0002, 1'b1);
        issue("sra_w",      6'h0E, 16'h8003, 16'h0000, 16'h0000, 16'hC001, 16'h0005, 1'b1);
        issue("sra_b",      6'h2E, 16'h1281, 16'h0000, 16'h0000, 16'h12C0, 16'h0005, 1'b1);
        issue("swpb",       6'h10, 16'h1234, 16'h0000, 16'h0007, 16'h3412, 16'h0001, 1'b1);
        issue("swap",       6'h0D, 16'h0000, 16'h5A5A, 16'h0000, 16'h5A5A, 16'h0000, 1'b0);
        issue("reserved",   6'h14, 16'h4321, 16'hFFFF, 16'h001F, 16'h4321, 16'h001F, 1'b0);
        issue("add_b_carry",6'h20, 16'h12FF, 16'h0001, 16'h0000, 16'h1200, 16'h0003, 1'b1);
        issue("dadd_b",     6'h24, 16'h5599, 16'h0001, 16'h0000, 16'h5500, 16'h0003, 1'b1);
        issue("add_b_ovf",  6'h20, 16'h007F, 16'h0001, 16'h0000, 16'h0080, 16'h0014, 1'b1);
        issue("slp_add",    6'h00, 16'h0001, 16'h0001, 16'h0008, 16'h0002, 16'h0008, 1'b1);
        issue("slp_and",    6'h07, 16'hF0F0, 16'h0F0F, 16'hFFE8, 16'h0000, 16'hFFEA, 1'b1);
        issue("mov",        6'h0C, 16'h0000, 16'hBEEF, 16'h0013, 16'hBEEF, 16'h0013, 1'b0);

        // Idle cycle: outputs must hold the MOV result.
        @(negedge Clock);
        bus.alu_E  = 1'b0;
        bus.alu_op = 6'h00;
        bus.d_bus  = 16'h1111;
        bus.s_bus  = 16'h2222;
        bus.PSW_in = 16'h0000;
        @(negedge Clock);
        chk("hold.alu_out",    bus.alu_out,         16'hBEEF);
        chk("hold.PSW_out",    bus.PSW_out,         16'h0013);
        chk("hold.psw_update", 16'(bus.psw_update), 16'h0000);

        // Reset arriving before the edge that would latch an ADD.
        bus.alu_op = 6'h00;
        bus.d_bus  = 16'h7FFF;
        bus.s_bus  = 16'h0001;
        bus.PSW_in = 16'h0008;
        bus.alu_E  = 1'b1;
        #3;
        Reset_n = 1'b0;
        #1;
        chk("midrst.alu_out",    bus.alu_out,         16'h0000);
        chk("midrst.PSW_out",    bus.PSW_out,         16'h0000);
        chk("midrst.psw_update", 16'(bus.psw_update), 16'h0000);
        @(negedge Clock);
        bus.alu_E = 1'b0;
        Reset_n   = 1'b1;
        @(posedge Clock);
        #1;
        chk("postrst.alu_out",    bus.alu_out,         16'h0000);
        chk("postrst.psw_update", 16'(bus.psw_update), 16'h0000);

        @(negedge Clock);
        @(negedge Clock);
        chk("queue_drained", 16'(exp_q.size()), 16'h0000);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
